// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: arbitration states and grant codes.
// No logic here; state and grant encodings are kept equal on purpose so the
// grant output is a direct view of the registered owner.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_D = 2'b01,
    SERVE_I = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_D    = 2'b01;
  localparam logic [1:0] GRANT_I    = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the data port (D) and prefetch port (I).
// Latency: one IDLE cycle from request to q_m_access; acks and read data are combinational pass-through.
// Backpressure: the requester holds its access until its ack; D wins ties until MAX_D_BURST consecutive D completions.
module mem_bus_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:1] d_m_addr,
  input  logic [15:0] d_m_data_out,
  output logic [15:0] d_m_data_in,
  input  logic        d_m_access,
  output logic        d_m_ack,
  input  logic        d_m_wr_en,
  input  logic [1:0]  d_m_bytesel,
  input  logic        d_lock,
  input  logic [19:1] i_m_addr,
  output logic [15:0] i_m_data_in,
  input  logic        i_m_access,
  output logic        i_m_ack,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic [1:0]  grant
);
  import mem_bus_arbiter_pkg::*;

  localparam int              SW         = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_BURST);

  arb_state_t     state, state_nxt;
  logic [SW-1:0]  d_streak, d_streak_nxt;

  // Owner and D-streak registers; reset abandons any bus cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      d_streak <= '0;
    end else begin
      state    <= state_nxt;
      d_streak <= d_streak_nxt;
    end
  end

  // Next owner and streak: D keeps winning ties only while I has not yet waited out a full burst.
  always_comb begin
    state_nxt    = state;
    d_streak_nxt = d_streak;
    case (state)
      IDLE: begin
        if (d_m_access && (!i_m_access || (d_streak < STREAK_MAX)))
          state_nxt = SERVE_D;
        else if (i_m_access)
          state_nxt = SERVE_I;
      end
      SERVE_D: begin
        if (q_m_ack) begin
          // Locked transfers keep the bus for the second half with no idle gap.
          state_nxt = d_lock ? SERVE_D : IDLE;
          if (i_m_access)
            d_streak_nxt = (d_streak == STREAK_MAX) ? d_streak : d_streak + 1'b1;
          else
            d_streak_nxt = '0;
        end else if (!d_m_access && !d_lock) begin
          state_nxt = IDLE;
        end
      end
      SERVE_I: begin
        if (q_m_ack) begin
          state_nxt    = IDLE;
          d_streak_nxt = '0;
        end else if (!i_m_access) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus routing from the current owner; an ack seen in IDLE goes nowhere.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    d_m_ack      = 1'b0;
    i_m_ack      = 1'b0;
    grant        = GRANT_NONE;
    case (state)
      SERVE_D: begin
        grant        = GRANT_D;
        q_m_access   = d_m_access & ~q_m_ack;
        q_m_addr     = d_m_addr;
        q_m_data_out = d_m_data_out;
        q_m_wr_en    = d_m_wr_en;
        q_m_bytesel  = d_m_bytesel;
        d_m_ack      = q_m_ack;
      end
      SERVE_I: begin
        grant        = GRANT_I;
        q_m_access   = i_m_access & ~q_m_ack;
        q_m_addr     = i_m_addr;
        q_m_bytesel  = 2'b11;
        i_m_ack      = q_m_ack;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each requester qualifies it with its own ack.
  assign d_m_data_in = q_m_data_in;
  assign i_m_data_in = q_m_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an ownership-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_mem_bus_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:1] d_m_addr = '0;
  logic [15:0] d_m_data_out = '0;
  logic [15:0] d_m_data_in;
  logic        d_m_access = 1'b0;
  logic        d_m_ack;
  logic        d_m_wr_en = 1'b0;
  logic [1:0]  d_m_bytesel = '0;
  logic        d_lock = 1'b0;
  logic [19:1] i_m_addr = '0;
  logic [15:0] i_m_data_in;
  logic        i_m_access = 1'b0;
  logic        i_m_ack;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in = '0;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack = 1'b0;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic [1:0]  grant;

  mem_bus_arbiter #(.MAX_D_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_data_in(d_m_data_in),
    .d_m_access(d_m_access), .d_m_ack(d_m_ack), .d_m_wr_en(d_m_wr_en),
    .d_m_bytesel(d_m_bytesel), .d_lock(d_lock),
    .i_m_addr(i_m_addr), .i_m_data_in(i_m_data_in), .i_m_access(i_m_access),
    .i_m_ack(i_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: who owns the bus (0 nobody, 1 data, 2 instruction) and
  // how many data completions in a row happened while I was waiting.
  int m_owner = 0;
  int m_streak = 0;

  // Bus responder: acks once access has been visible for bus_lat cycles.
  bit auto_bus = 0;
  int bus_lat = 1;
  int bus_wait = 0;

  // Observations from the most recent cycle.
  logic        last_q_acc, last_d_ack, last_i_ack, last_wr;
  logic [1:0]  last_grant, last_bs;
  logic [15:0] last_d_data;
  int n_dack = 0;
  int n_iack = 0;
  int ack_log[$];
  string phase = "init";

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [74:0] model_outs();
    logic        acc, wr, da, ia;
    logic [19:1] addr;
    logic [15:0] dout;
    logic [1:0]  bs;
    acc = 0; wr = 0; da = 0; ia = 0; addr = '0; dout = '0; bs = '0;
    if (m_owner == 1) begin
      acc = d_m_access && !q_m_ack; addr = d_m_addr; dout = d_m_data_out;
      wr = d_m_wr_en; bs = d_m_bytesel; da = q_m_ack;
    end else if (m_owner == 2) begin
      acc = i_m_access && !q_m_ack; addr = i_m_addr; bs = 2'b11; ia = q_m_ack;
    end
    return {2'(m_owner), acc, addr, dout, wr, bs, da, ia, q_m_data_in, q_m_data_in};
  endfunction

  function automatic void model_step();
    if (m_owner == 0) begin
      if (d_m_access && (!i_m_access || m_streak < MAXB)) m_owner = 1;
      else if (i_m_access) m_owner = 2;
    end else if (m_owner == 1) begin
      if (q_m_ack) begin
        m_streak = i_m_access ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
        if (!d_lock) m_owner = 0;
      end else if (!d_m_access && !d_lock) begin
        m_owner = 0;
      end
    end else begin
      if (q_m_ack) begin m_streak = 0; m_owner = 0; end
      else if (!i_m_access) m_owner = 0;
    end
  endfunction

  // One clock cycle: entered and left 1 unit after a rising edge.
  task automatic cyc();
    if (auto_bus) q_m_ack = (bus_wait >= bus_lat);
    #3;
    chk(phase, {grant, q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel,
                d_m_ack, i_m_ack, d_m_data_in, i_m_data_in}, model_outs());
    last_q_acc = q_m_access; last_d_ack = d_m_ack; last_i_ack = i_m_ack;
    last_grant = grant; last_wr = q_m_wr_en; last_bs = q_m_bytesel; last_d_data = d_m_data_in;
    if (d_m_ack) begin n_dack++; ack_log.push_back(1); end
    if (i_m_ack) begin n_iack++; ack_log.push_back(2); end
    if (q_m_ack) bus_wait = 0;
    else if (q_m_access) bus_wait++;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    d_m_access = 0; i_m_access = 0; d_lock = 0; q_m_ack = 0; d_m_wr_en = 0;
    auto_bus = 0; bus_wait = 0; m_owner = 0; m_streak = 0;
    cyc(); cyc();
    reset_n = 1;
    n_dack = 0; n_iack = 0; ack_log.delete();
  endtask

  initial begin
    bit got;
    @(posedge clk); #1;

    // Reset state
    phase = "reset";
    do_reset();
    chk("reset_grant", last_grant, 2'b00);
    chk("reset_access", last_q_acc, 0);

    // 1: D-only read, bus acks 3 cycles after access rises
    phase = "t1";
    auto_bus = 1; bus_lat = 3; q_m_data_in = 16'hBEEF;
    d_m_access = 1; d_m_addr = 19'h00100; d_m_wr_en = 0; d_m_bytesel = 2'b11;
    cyc(); chk("t1_arb_gap", last_q_acc, 0);
    cyc(); chk("t1_access_rise", last_q_acc, 1);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc();
      if (last_d_ack) begin got = 1; chk("t1_rdata", last_d_data, 16'hBEEF); end
    end
    chk("t1_ack_seen", got, 1);
    d_m_access = 0;
    cyc(); cyc();
    chk("t1_end_idle", last_grant, 2'b00);
    chk("t1_dack_once", n_dack, 1);
    chk("t1_no_iack", n_iack, 0);

    // 2: locked unaligned write with I waiting throughout
    phase = "t2";
    do_reset();
    d_m_access = 1; i_m_access = 1; d_lock = 1; d_m_wr_en = 1;
    d_m_addr = 19'h01230; d_m_data_out = 16'h55AA; d_m_bytesel = 2'b10;
    cyc(); chk("t2_arb", last_grant, 2'b00);
    cyc(); chk("t2_g1", last_grant, 2'b01); chk("t2_wr1", last_wr, 1);
    q_m_ack = 1;
    cyc(); chk("t2_ack1", last_d_ack, 1);
    q_m_ack = 0; d_lock = 0; d_m_addr = 19'h01231; d_m_bytesel = 2'b01;
    cyc(); chk("t2_g2", last_grant, 2'b01); chk("t2_acc2", last_q_acc, 1); chk("t2_wr2", last_wr, 1);
    q_m_ack = 1;
    cyc(); chk("t2_ack2", last_d_ack, 1); chk("t2_g3", last_grant, 2'b01);
    q_m_ack = 0; d_m_access = 0;
    cyc(); chk("t2_iack_none", n_iack, 0);
    cyc(); chk("t2_i_after", last_grant, 2'b10);

    // 3/4: continuous D and I requests, tie goes to D until the burst limit
    phase = "t4";
    do_reset();
    auto_bus = 1; bus_lat = 1; d_m_wr_en = 0;
    d_m_access = 1; i_m_access = 1; d_lock = 0;
    for (int k = 0; k < 300 && ack_log.size() < 25; k++) cyc();
    chk("t4_ack_count", (ack_log.size() >= 25), 1);
    for (int k = 0; k < 25 && k < ack_log.size(); k++)
      chk($sformatf("t4_order_%0d", k), ack_log[k], ((k % (MAXB + 1)) == MAXB) ? 2 : 1);

    // 5: instruction fetch ignores the D write controls
    phase = "t5";
    do_reset();
    auto_bus = 1; bus_lat = 2;
    i_m_access = 1; i_m_addr = 19'h7ABCD; d_m_access = 0; d_m_wr_en = 1; d_m_bytesel = 2'b00;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (last_grant == 2'b10) begin
        chk("t5_wr", last_wr, 0);
        chk("t5_bs", last_bs, 2'b11);
      end
    end
    chk("t5_iack", (n_iack > 0), 1);

    // 6: reset mid-SERVE_D, then a stray ack in IDLE
    phase = "t6";
    do_reset();
    d_m_access = 1; d_m_wr_en = 1;
    cyc(); cyc();
    chk("t6_in_d", last_grant, 2'b01);
    reset_n = 0; m_owner = 0; m_streak = 0;
    #1;
    chk("t6_rst_acc", q_m_access, 0);
    chk("t6_rst_grant", grant, 2'b00);
    #1;
    cyc();
    reset_n = 1; d_m_access = 0; q_m_ack = 1;
    cyc(); chk("t6_stray_d", last_d_ack, 0); chk("t6_stray_i", last_i_ack, 0);
    q_m_ack = 0;
    cyc(); chk("t6_still_idle", last_grant, 2'b00);
    // Streak must be zero after reset: a tie goes to D.
    d_m_access = 1; i_m_access = 1;
    cyc(); cyc(); chk("t6_streak0", last_grant, 2'b01);

    // Randomized traffic against the model
    phase = "rand";
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      d_m_access   = ($urandom_range(0, 9) < 6);
      i_m_access   = ($urandom_range(0, 9) < 6);
      d_lock       = ($urandom_range(0, 9) < 3);
      d_m_wr_en    = $urandom_range(0, 1);
      d_m_bytesel  = 2'($urandom_range(0, 3));
      d_m_addr     = 19'($urandom);
      i_m_addr     = 19'($urandom);
      d_m_data_out = 16'($urandom);
      q_m_data_in  = 16'($urandom);
      q_m_ack      = ($urandom_range(0, 9) < 3);
      if (k % 500 == 499) begin
        reset_n = 0; m_owner = 0; m_streak = 0;
        cyc();
        reset_n = 1;
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
